// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan_seq8 index sequencer.
package scan_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned N_IDX = 8;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StBlank
    } state_t;

endpackage

// File: rtl/mask_next8.sv
// Circular find-next-set-bit over an 8-bit mask, starting just above cur.
// Passing cur=7 yields the lowest set bit.
module mask_next8
    import scan_pkg::*;
(
    input  logic [N_IDX-1:0] mask,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] nxt,
    output logic             wrapped,
    output logic             none
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        nxt     = cur;
        wrapped = 1'b0;
        none    = (mask == '0);
        found   = 1'b0;
        idx     = cur;
        // k=8 lands back on cur itself, so a lone set bit still wraps onto itself.
        for (int k = 1; k <= N_IDX; k++) begin
            idx = cur + IDX_W'(k);
            if (!found && mask[idx]) begin
                found   = 1'b1;
                nxt     = idx;
                wrapped = (idx <= cur);
            end
        end
    end

endmodule

// File: rtl/scan_seq8.sv
// Index sequencer driving a 3-to-8 decoder: ascending masked sweep with
// programmable dwell, optional blanking, single or continuous laps.
module scan_seq8
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_IDX-1:0]   mask,
    output logic [IDX_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   nxt_q, nxt_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic               mode_q, mode_d;
    logic               wrap_pend_q, wrap_pend_d;
    logic               en_q, busy_q, done_q, wrap_q;
    logic               done_d, wrap_d;

    logic [IDX_W-1:0]   search_cur;
    logic [IDX_W-1:0]   found_idx;
    logic               found_wrapped;
    logic               found_none;

    // In IDLE the search starts above index 7, giving the lowest set bit.
    assign search_cur = (state_q == StIdle) ? IDX_W'(N_IDX - 1) : sel_q;

    mask_next8 u_next (
        .mask    (mask),
        .cur     (search_cur),
        .nxt     (found_idx),
        .wrapped (found_wrapped),
        .none    (found_none)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        nxt_d       = nxt_q;
        cnt_d       = cnt_q;
        blank_d     = blank_q;
        mode_d      = mode_q;
        wrap_pend_d = wrap_pend_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (found_none) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StActive;
                            sel_d   = found_idx;
                            cnt_d   = dwell;
                            mode_d  = mode;
                        end
                    end
                end
                StActive: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (found_none || (!mode_q && found_wrapped)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (BLANK_CYC == 0) begin
                        sel_d  = found_idx;
                        cnt_d  = dwell;
                        wrap_d = found_wrapped;
                    end else begin
                        state_d     = StBlank;
                        nxt_d       = found_idx;
                        blank_d     = BW'(BLANK_CYC - 1);
                        wrap_pend_d = found_wrapped;
                    end
                end
                StBlank: begin
                    if (blank_q == '0) begin
                        state_d = StActive;
                        sel_d   = nxt_q;
                        cnt_d   = dwell;
                        wrap_d  = wrap_pend_q;
                    end else begin
                        blank_d = blank_q - BW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            nxt_q       <= '0;
            cnt_q       <= '0;
            blank_q     <= '0;
            mode_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            nxt_q       <= nxt_d;
            cnt_q       <= cnt_d;
            blank_q     <= blank_d;
            mode_q      <= mode_d;
            wrap_pend_q <= wrap_pend_d;
            en_q        <= (state_d == StActive);
            busy_q      <= (state_d != StIdle);
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: doc/scan_seq8.md
# scan_seq8

Index sequencer that drives the 3-bit select and enable inputs of the team's 3-to-8 one-hot decoder. It steps through the eight decoder outputs in ascending order, skipping any masked-off index. Each index is held for a programmable dwell time, with an optional blanking gap between indices. It supports single-sweep and continuous modes and sits directly upstream of the decoder in scanned-display and strobe-channel paths.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `BLANK_CYC`, default 1: number of enable-low cycles inserted between indices. 0 disables blanking.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `stop` in 1: abort. Sampled in every state and has highest priority.
- `mode` in 1: 0 = single sweep, 1 = continuous. Sampled on start.
- `dwell` in DWELL_W: hold count D. Enable is high for D+1 cycles per index. Sampled on each index entry.
- `mask` in 8: bit i = 1 means index i is visited. Sampled live at start and at each advance.
- `sel` out 3: index to the decoder's select input.
- `en` out 1: decoder enable.
- `busy` out 1: high in ACTIVE and BLANK.
- `done` out 1: one-cycle pulse at the end of a single sweep, or when the mask empties mid-run.
- `wrap` out 1: one-cycle pulse on the first ACTIVE cycle of each new lap in continuous mode.

## Operation
- States: IDLE, ACTIVE, BLANK.
- Reset values: `sel`=0, `en`=0, `busy`=0, `done`=0, `wrap`=0; state IDLE; dwell counter 0.
- IDLE → ACTIVE: on `start`=1, `stop`=0, and `mask`≠0.
  - `sel` loads the lowest set mask bit.
  - Dwell counter loads `dwell`.
  - `mode` is latched.
- `start` in IDLE with `mask`=0: stay IDLE and pulse `done` the next cycle.
- `start` outside IDLE is ignored.
- ACTIVE: `en`=1 and the dwell counter decrements. When the counter is 0, the FSM advances:
  - The next index is the next set bit above `sel` in the current `mask`, searching circularly.
  - Single mode, no set bit above `sel`: go to IDLE and pulse `done`. No trailing blank.
  - Continuous mode, search wraps past index 7: the lap restarts at the lowest set bit and `wrap` pulses on that first ACTIVE cycle.
  - `mask`=0 at advance: go to IDLE and pulse `done`, in either mode.
  - Otherwise: go to BLANK for BLANK_CYC cycles, or directly to the next ACTIVE if BLANK_CYC=0.
- BLANK: `en`=0 and `sel` holds the previous index. On exit, `sel` takes the precomputed next index and the dwell counter reloads from `dwell`.
- `stop`=1 in any state: IDLE on the next edge.
  - `en`=0, `busy`=0.
  - No `done`, no `wrap`.
  - `stop` wins over a simultaneous `start` or advance.
- `sel` holds its last value in IDLE. `en` is 0 whenever the state is not ACTIVE.
- Mask changes are honoured only at advance points. The index currently being held is never cut short.
- `rst` mid-sweep: all outputs return to reset values on the next edge.

## Timing
- Latency: `start` sampled at edge N gives `en`=1 with the first index during cycle N+1.
- Per index: D+1 ACTIVE cycles, then BLANK_CYC blank cycles.
  - Index period is D+1+BLANK_CYC cycles.
  - Single sweep over k indices takes k(D+1)+(k-1)·BLANK_CYC cycles.
- Timing of `done`:
  - It is high in the cycle after the last ACTIVE cycle, with `busy`=0 in the same cycle.
  - It pulses in the cycle after a rejected `start`.
- `wrap` is coincident with `en` rising on the lap's first index.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `scan_pkg`:
  - State enum {IDLE, ACTIVE, BLANK}.
  - `IDX_W`=3 and `N_IDX`=8 localparams.
- Sub-module `mask_next8`: combinational circular find-next-set-bit.
  - Inputs: 8-bit mask, 3-bit current index.
  - Outputs: next index, wrapped flag, none-found flag.
  - Reused for the lowest-set-bit search by passing index 7.

## Test plan
- Full single sweep. Setup: `mask`=8'hFF, `dwell`=0, BLANK_CYC=1, `mode`=0, `start` at cycle 0. Expected:
  - `en` high on odd cycles 1–15 with `sel`=0..7.
  - `done` pulses at cycle 16 with `busy`=0.
- Sparse continuous sweep. Setup: `mask`=8'b1010_0100, `dwell`=2, `mode`=1. Expected:
  - `sel`=2 on cycles 1–3, blank on 4.
  - `sel`=5 on cycles 5–7, blank on 8.
  - `sel`=7 on cycles 9–11, blank on 12.
  - `sel`=2 from cycle 13 with `wrap`=1 at cycle 13.
- Stop mid-dwell. Setup: assert `stop` at cycle 2 of test 2. Expected: at cycle 3 `en`=0, `busy`=0, state IDLE, no `done`; `sel` holds 2.
- Start with empty mask. Setup: `start` with `mask`=0. Expected: `done` pulse one cycle later, `en` never rises. `start`+`stop` together in IDLE gives no activity.
- Mask change mid-run. Setup: continuous `mask`=8'h11, `dwell`=3; clear bit 4 while `sel`=0. Expected: index 0 completes 4 cycles, then `wrap` and `sel`=0 again. Clearing to `mask`=0 instead gives IDLE with `done`.
- Reset mid-sweep. Setup: pulse `rst` during BLANK. Expected: next edge gives all outputs 0. A `start` afterwards gives a clean first index one cycle later.
